register_file: RTL and testbench
================================

# register_file

Multi-ported general-purpose register file for the RISC-V integer datapath, sitting between decode (register addresses) and execute/writeback. It provides two read ports and one write port, all synchronous to a single clock. Register 0 is hard-wired to zero, per the RISC-V convention. Read data is registered, so operand values become available one cycle after the addresses are presented.

## Interface
Parameters:
- WIDTH, 32: bit width of each register and of each data port.
- DEPTH, 32: number of registers. The address width is AW = $clog2(DEPTH).

Ports:
- clk  input  1  the single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- wr_en  input  1  write enable for port W.
- regW  input  AW  write address.
- portW  input  WIDTH  write data.
- regA  input  AW  read address, port A.
- regB  input  AW  read address, port B.
- portA  output  WIDTH  registered read data, port A.
- portB  output  WIDTH  registered read data, port B.

## Operation
- Storage is an array regs[0..DEPTH-1] of WIDTH-bit registers.
- **Write:**
  - At a rising clk edge with rst high and wr_en=1, regs[regW] <= portW.
  - If regW=0 the write is discarded, so regs[0] always stays 0.
- **Read:**
  - At every rising clk edge with rst high, portA <= regs[regA] and portB <= regs[regB].
  - The sampled values are the contents before any write at that same edge (read-before-write, no bypass).
- Reading address 0 always returns 0.
- Ports A and B are independent and may address the same register, including regW.
- **Reset:** while rst=0, asynchronously and immediately:
  - every entry in regs is cleared to 0;
  - portA and portB are cleared to 0;
  - writes are ignored for as long as rst is low.
- There is no handshake. Every cycle performs a read on both ports, and a write when wr_en=1.
- Addresses are always in range when DEPTH is a power of two. If DEPTH is not a power of two:
  - reads from an address >= DEPTH return 0;
  - writes to an address >= DEPTH are ignored.

## Timing
- Read latency is 1 cycle: an address applied before edge N produces data on the port after edge N.
- Write latency is 1 cycle: data written at edge N is visible on a read port after edge N+1 when that register is addressed.
- Same-edge write and read of one register: the port shows the old value after edge N and the new value after edge N+1 if the address is held.
- Reset:
  - Asserting rst mid-operation clears all outputs and storage without waiting for a clock edge.
  - After rst deasserts, the first rising edge performs normal reads and writes.
- Outputs after reset, before the first edge: portA=0, portB=0.

## Test plan
- **Reset:** hold rst=0 for 5 cycles, then release; read registers 1..31 on both ports -> every value is 0x00000000.
- **Write then read:**
  - Stimulus: wr_en=1, regW=5, portW=0xDEADBEEF at edge N; then regA=5 at edge N+1.
  - Response: portA=0xDEADBEEF after edge N+1; portB on regB=5 matches.
- **Register 0 protection:** wr_en=1, regW=0, portW=0xFFFFFFFF, then regA=0 and regB=0 -> portA=portB=0 on every following cycle.
- **Read-before-write:**
  - Stimulus: regs[7]=0x11111111; at one edge, wr_en=1, regW=7, portW=0x22222222, regA=7.
  - Response: portA=0x11111111 after that edge, then 0x22222222 after the next edge.
- **wr_en=0 hold:** with wr_en=0, drive random regW/portW for 100 cycles -> no register changes; portB tracks regs[regB] with 1-cycle latency.
- **Random soak:**
  - Stimulus: 10000 cycles of random wr_en, regW, regA, regB, portW, with an asynchronous rst pulse mid-run.
  - Response: outputs match a reference array model every cycle; all outputs and storage are 0 immediately after the pulse.

Source files
------------

// File: rtl/register_file.sv
// register_file: two registered read ports, one write port, x0 hard-wired to zero.
// Reads sample storage before a same-edge write (no bypass); reset clears storage and outputs.
module register_file #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    regW,
  input  logic [WIDTH-1:0] portW,
  input  logic [AW-1:0]    regA,
  input  logic [AW-1:0]    regB,
  output logic [WIDTH-1:0] portA,
  output logic [WIDTH-1:0] portB
);

  localparam bit         FULL_RANGE = (DEPTH == (1 << AW));
  localparam logic [AW:0] DEPTH_W   = DEPTH[AW:0];

  logic [WIDTH-1:0] regs [DEPTH];
  logic             w_ok;
  logic             a_ok;
  logic             b_ok;

  // Address range qualifiers only matter when DEPTH leaves holes in the address space.
  generate
    if (FULL_RANGE) begin : g_full
      assign w_ok = 1'b1;
      assign a_ok = 1'b1;
      assign b_ok = 1'b1;
    end else begin : g_part
      assign w_ok = ({1'b0, regW} < DEPTH_W);
      assign a_ok = ({1'b0, regA} < DEPTH_W);
      assign b_ok = ({1'b0, regB} < DEPTH_W);
    end
  endgenerate

  // Storage: clear on reset, otherwise accept writes to in-range nonzero addresses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en && (regW != '0) && w_ok) begin
      regs[regW] <= portW;
    end
  end

  // Read ports: register the pre-write contents; x0 and out-of-range addresses read as zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      portA <= '0;
      portB <= '0;
    end else begin
      portA <= (a_ok && (regA != '0)) ? regs[regA] : '0;
      portB <= (b_ok && (regB != '0)) ? regs[regB] : '0;
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: directed vector table, hold test, randomized soak against an array model.
module tb_register_file;

  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic             clk;
  logic             rst;
  logic             wr_en;
  logic [AW-1:0]    regW;
  logic [WIDTH-1:0] portW;
  logic [AW-1:0]    regA;
  logic [AW-1:0]    regB;
  logic [WIDTH-1:0] portA;
  logic [WIDTH-1:0] portB;

  int checks;
  int errors;

  logic [WIDTH-1:0] model [DEPTH];

  typedef struct {
    logic             we;
    logic [AW-1:0]    w;
    logic [WIDTH-1:0] d;
    logic [AW-1:0]    a;
    logic [AW-1:0]    b;
    logic [WIDTH-1:0] exp_a;
    logic [WIDTH-1:0] exp_b;
  } vec_t;

  vec_t vecs [9];

  register_file #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .wr_en (wr_en),
    .regW  (regW),
    .portW (portW),
    .regA  (regA),
    .regB  (regB),
    .portA (portA),
    .portB (portB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, advance the model, and return the values the ports should show after the edge.
  task automatic cycle(input logic we, input logic [AW-1:0] w, input logic [WIDTH-1:0] d,
                       input logic [AW-1:0] a, input logic [AW-1:0] b,
                       output logic [WIDTH-1:0] ea, output logic [WIDTH-1:0] eb);
    @(negedge clk);
    wr_en = we; regW = w; portW = d; regA = a; regB = b;
    @(posedge clk);
    ea = (a == 0) ? '0 : model[a];
    eb = (b == 0) ? '0 : model[b];
    if (we && w != 0) model[w] = d;
    #1;
  endtask

  task automatic rand_step(input string name, input logic allow_wr);
    logic [WIDTH-1:0] ea, eb;
    cycle(allow_wr & 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), ea, eb);
    chk({name, "_a"}, portA, ea);
    chk({name, "_b"}, portB, eb);
  endtask

  task automatic sweep_zero(input string name);
    logic [WIDTH-1:0] ea, eb;
    for (int r = 1; r < DEPTH; r++) begin
      cycle(1'b0, '0, '0, 5'(r), 5'(DEPTH - r), ea, eb);
      chk({name, "_a"}, portA, 32'h0);
      chk({name, "_b"}, portB, 32'h0);
    end
  endtask

  initial begin
    logic [WIDTH-1:0] ea, eb;
    checks = 0;
    errors = 0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;

    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd0,  5'd0,  32'h0,        32'h0};
    vecs[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0,        32'h0};
    vecs[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0};
    vecs[4] = '{1'b1, 5'd7,  32'h11111111, 5'd7,  5'd5,  32'h0,        32'hDEADBEEF};
    vecs[5] = '{1'b1, 5'd7,  32'h22222222, 5'd7,  5'd7,  32'h11111111, 32'h11111111};
    vecs[6] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd0,  32'h22222222, 32'h0};
    vecs[7] = '{1'b1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd1,  32'h0,        32'h0};
    vecs[8] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd31, 32'hA5A5A5A5, 32'hA5A5A5A5};

    rst = 1'b0; wr_en = 1'b0; regW = '0; portW = '0; regA = '0; regB = '0;
    #1;
    chk("reset_initial_a", portA, 32'h0);
    chk("reset_initial_b", portB, 32'h0);

    // Reset held for 5 cycles with writes presented; nothing may land.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      wr_en = 1'b1; regW = 5'(i + 1); portW = 32'hCAFE0000 + i; regA = 5'(i + 1); regB = 5'(i + 1);
      @(posedge clk); #1;
      chk("reset_hold_a", portA, 32'h0);
      chk("reset_hold_b", portB, 32'h0);
    end
    @(negedge clk);
    wr_en = 1'b0;
    rst = 1'b1;
    sweep_zero("reset_sweep");

    // Directed vectors.
    for (int i = 0; i < 9; i++) begin
      cycle(vecs[i].we, vecs[i].w, vecs[i].d, vecs[i].a, vecs[i].b, ea, eb);
      chk($sformatf("vec%0d_a", i), portA, vecs[i].exp_a);
      chk($sformatf("vec%0d_b", i), portB, vecs[i].exp_b);
    end

    // Register 0 protection: repeated writes to x0 never show up.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, ea, eb);
      chk("x0_a", portA, 32'h0);
      chk("x0_b", portB, 32'h0);
    end

    // wr_en low: random write address/data must not change anything.
    for (int i = 0; i < 100; i++) rand_step("hold", 1'b0);
    chk("hold_r5", (model[5] == 32'hDEADBEEF) ? 32'h1 : 32'h0, 32'h1);

    // Random soak with an asynchronous reset pulse in the middle.
    for (int i = 0; i < 10000; i++) begin
      rand_step("soak", 1'b1);
      if (i == 5000) begin
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_a", portA, 32'h0);
        chk("async_rst_b", portB, 32'h0);
        for (int r = 0; r < DEPTH; r++) model[r] = '0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          wr_en = 1'b1; regW = 5'($urandom_range(1, 31)); portW = $urandom;
          regA = 5'($urandom_range(0, 31)); regB = 5'($urandom_range(0, 31));
          @(posedge clk); #1;
          chk("rst_low_a", portA, 32'h0);
          chk("rst_low_b", portB, 32'h0);
        end
        @(negedge clk);
        wr_en = 1'b0;
        rst = 1'b1;
        sweep_zero("post_rst_sweep");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
